// File: rtl/datapath_seq_if.sv
// Request/response bundle between the controller and the sequenced datapath.
// The controller side drives a command and the live memory/PC values.
// The datapath side returns handshake, result, status and debug read data.
interface datapath_seq_if #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int PCW   = 8
);
    localparam int AW = $clog2(NREGS);

    logic             start;
    logic [AW-1:0]    rd;
    logic [AW-1:0]    rn;
    logic [AW-1:0]    rm;
    logic [1:0]       alu_op;
    logic [1:0]       shift;
    logic             a_zero;
    logic             use_imm;
    logic [WIDTH-1:0] imm;
    logic [1:0]       wsrc;
    logic             wen;
    logic             set_status;
    logic [WIDTH-1:0] mdata;
    logic [PCW-1:0]   pc;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [2:0]       status;
    logic [AW-1:0]    dbg_addr;
    logic [WIDTH-1:0] dbg_data;

    modport master (
        output start, rd, rn, rm, alu_op, shift, a_zero, use_imm, imm,
               wsrc, wen, set_status, mdata, pc, dbg_addr,
        input  ready, done, result, status, dbg_data
    );

    modport slave (
        input  start, rd, rn, rm, alu_op, shift, a_zero, use_imm, imm,
               wsrc, wen, set_status, mdata, pc, dbg_addr,
        output ready, done, result, status, dbg_data
    );
endinterface

// File: rtl/datapath_seq.sv
// Self-sequencing datapath: register file, A/B/C registers and {V,N,Z} status.
// One command per start/done handshake; ALU commands walk LD_A, LD_B, EXEC, WB,
// load-style commands (pc/imm/mdata writeback) jump straight to WB.
module datapath_seq #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int PCW   = 8
) (
    input  logic          clk,
    input  logic          reset,
    datapath_seq_if.slave bus
);
    localparam int AW  = $clog2(NREGS);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [2:0] {S_IDLE, S_LD_A, S_LD_B, S_EXEC, S_WB} state_t;

    typedef struct packed {
        logic [AW-1:0]    rd;
        logic [AW-1:0]    rn;
        logic [AW-1:0]    rm;
        logic [1:0]       alu_op;
        logic [1:0]       shift;
        logic             a_zero;
        logic             use_imm;
        logic [WIDTH-1:0] imm;
        logic [1:0]       wsrc;
        logic             wen;
        logic             set_status;
    } cmd_t;

    state_t           state_q, state_d;
    cmd_t             cmd_q, cmd_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [2:0]       status_q, status_d;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];

    logic             ready_c;
    logic             done_c;
    logic [WIDTH-1:0] ain;
    logic [WIDTH-1:0] bsh;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] alu_out;
    logic             alu_v;
    logic [WIDTH-1:0] wb_data;

    // ALU operand selection, B-path shifter and result/overflow
    always_comb begin
        ain = cmd_q.a_zero ? '0 : a_q;
        bsh = b_q;
        case (cmd_q.shift)
            2'b01:   bsh = {b_q[MSB-1:0], 1'b0};
            2'b10:   bsh = {1'b0, b_q[MSB:1]};
            2'b11:   bsh = {b_q[MSB], b_q[MSB:1]};
            default: bsh = b_q;
        endcase
        bin     = cmd_q.use_imm ? cmd_q.imm : bsh;
        alu_out = ain + bin;
        alu_v   = 1'b0;
        case (cmd_q.alu_op)
            2'b00: begin
                alu_out = ain + bin;
                alu_v   = (ain[MSB] == bin[MSB]) && (alu_out[MSB] != ain[MSB]);
            end
            2'b01: begin
                alu_out = ain - bin;
                alu_v   = (ain[MSB] != bin[MSB]) && (alu_out[MSB] != ain[MSB]);
            end
            2'b10:   alu_out = ain & bin;
            default: alu_out = ~bin;
        endcase
    end

    // Writeback source mux; pc and mdata are taken live at the WB edge
    always_comb begin
        wb_data = c_q;
        case (cmd_q.wsrc)
            2'b01:   wb_data = WIDTH'(bus.pc);
            2'b10:   wb_data = cmd_q.imm;
            2'b11:   wb_data = bus.mdata;
            default: wb_data = c_q;
        endcase
    end

    // Next-state and datapath register updates for the sequencing FSM
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        status_d = status_q;
        regs_d   = regs_q;
        ready_c  = 1'b0;
        done_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready_c = 1'b1;
                if (bus.start) begin
                    cmd_d.rd         = bus.rd;
                    cmd_d.rn         = bus.rn;
                    cmd_d.rm         = bus.rm;
                    cmd_d.alu_op     = bus.alu_op;
                    cmd_d.shift      = bus.shift;
                    cmd_d.a_zero     = bus.a_zero;
                    cmd_d.use_imm    = bus.use_imm;
                    cmd_d.imm        = bus.imm;
                    cmd_d.wsrc       = bus.wsrc;
                    cmd_d.wen        = bus.wen;
                    cmd_d.set_status = bus.set_status;
                    state_d = (bus.wsrc == 2'b00) ? S_LD_A : S_WB;
                end
            end
            S_LD_A: begin
                a_d     = regs_q[cmd_q.rn];
                state_d = S_LD_B;
            end
            S_LD_B: begin
                b_d     = regs_q[cmd_q.rm];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                c_d = alu_out;
                if (cmd_q.set_status) begin
                    status_d = {alu_v, alu_out[MSB], (alu_out == '0)};
                end
                state_d = S_WB;
            end
            S_WB: begin
                done_c = 1'b1;
                if (cmd_q.wen) begin
                    regs_d[cmd_q.rd] = wb_data;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, command, operand and register-file flops; reset clears everything
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cmd_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            status_q <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            status_q <= status_d;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign bus.ready    = ready_c;
    assign bus.done     = done_c;
    assign bus.result   = c_q;
    assign bus.status   = status_q;
    assign bus.dbg_data = regs_q[bus.dbg_addr];
endmodule

// File: tb/tb_datapath_seq.sv
// Randomised self-checking bench for datapath_seq (16-bit/8-reg and 8-bit/4-reg).
module tb_datapath_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #10 clk = ~clk;

    datapath_seq_if #(.WIDTH(16), .NREGS(8), .PCW(8)) bus16 ();
    datapath_seq_if #(.WIDTH(8),  .NREGS(4), .PCW(8)) bus8 ();

    datapath_seq #(.WIDTH(16), .NREGS(8), .PCW(8)) dut16 (.clk(clk), .reset(rst), .bus(bus16));
    datapath_seq #(.WIDTH(8),  .NREGS(4), .PCW(8)) dut8  (.clk(clk), .reset(rst), .bus(bus8));

    typedef struct {
        int     rd, rn, rm, op, sh;
        bit     az, ui;
        longint imm;
        int     wsrc;
        bit     wen, ss;
    } cmd_t;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] m_regs [8];
    logic [15:0] m_c;
    logic [2:0]  m_status;

    // Reference ALU from the arithmetic rules, using signed integers for overflow
    function automatic void model_alu(input int w, input longint a, input longint b,
                                      input int op, input int sh, input bit az, input bit ui,
                                      input longint imm, output longint res, output logic [2:0] st);
        longint m, half, ain, bb, sbv, bin, sa, sbn, full;
        bit v;
        m    = longint'(1) << w;
        half = m / 2;
        ain  = az ? 0 : a;
        case (sh)
            1: bb = (b * 2) % m;
            2: bb = b / 2;
            3: begin
                sbv = (b >= half) ? b - m : b;
                bb  = sbv >>> 1;
                if (bb < 0) bb = bb + m;
            end
            default: bb = b;
        endcase
        bin = ui ? imm : bb;
        sa  = (ain >= half) ? ain - m : ain;
        sbn = (bin >= half) ? bin - m : bin;
        v   = 1'b0;
        case (op)
            0: begin full = sa + sbn; v = (full >= half) || (full < -half); res = (ain + bin) % m; end
            1: begin full = sa - sbn; v = (full >= half) || (full < -half); res = (ain - bin + m) % m; end
            2: res = ain & bin;
            default: res = m - 1 - bin;
        endcase
        st = {v, (res >= half), (res == 0)};
    endfunction

    // Apply one command to the 16-bit model (called before issuing, pc/mdata held)
    function automatic void model16(input cmd_t c);
        longint res;
        logic [2:0] st;
        logic [15:0] wv;
        if (c.wsrc == 0) begin
            model_alu(16, longint'(m_regs[c.rn]), longint'(m_regs[c.rm]), c.op, c.sh,
                      c.az, c.ui, c.imm, res, st);
            m_c = 16'(res);
            if (c.ss) m_status = st;
        end
        case (c.wsrc)
            0: wv = m_c;
            1: wv = 16'(bus16.pc);
            2: wv = 16'(c.imm);
            default: wv = bus16.mdata;
        endcase
        if (c.wen) m_regs[c.rd] = wv;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_c = '0;
        m_status = '0;
    endfunction

    // Issue one command on the 16-bit DUT; returns cycles from accept to done,
    // then steps past the WB edge so the write is visible.
    task automatic issue16(input cmd_t c, output int cyc);
        bus16.rd = 3'(c.rd);  bus16.rn = 3'(c.rn);  bus16.rm = 3'(c.rm);
        bus16.alu_op = 2'(c.op); bus16.shift = 2'(c.sh);
        bus16.a_zero = c.az; bus16.use_imm = c.ui; bus16.imm = 16'(c.imm);
        bus16.wsrc = 2'(c.wsrc); bus16.wen = c.wen; bus16.set_status = c.ss;
        bus16.start = 1'b1;
        @(posedge clk); #1;
        bus16.start = 1'b0;
        bus16.rd = 3'($urandom); bus16.rn = 3'($urandom); bus16.rm = 3'($urandom);
        bus16.alu_op = 2'($urandom); bus16.shift = 2'($urandom);
        bus16.a_zero = 1'($urandom); bus16.use_imm = 1'($urandom); bus16.imm = 16'($urandom);
        bus16.wsrc = 2'($urandom); bus16.wen = 1'($urandom); bus16.set_status = 1'($urandom);
        cyc = 1;
        while (bus16.done !== 1'b1 && cyc < 12) begin
            @(posedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1;
        $display("[TB] op16 wsrc=%0d rd=%0d rn=%0d rm=%0d alu_op=%0d shift=%0d cycles=%0d result=%h status=%b",
                 c.wsrc, c.rd, c.rn, c.rm, c.op, c.sh, cyc, bus16.result, bus16.status);
    endtask

    task automatic issue8(input cmd_t c, output int cyc);
        bus8.rd = 2'(c.rd);  bus8.rn = 2'(c.rn);  bus8.rm = 2'(c.rm);
        bus8.alu_op = 2'(c.op); bus8.shift = 2'(c.sh);
        bus8.a_zero = c.az; bus8.use_imm = c.ui; bus8.imm = 8'(c.imm);
        bus8.wsrc = 2'(c.wsrc); bus8.wen = c.wen; bus8.set_status = c.ss;
        bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        bus8.imm = 8'($urandom); bus8.shift = 2'($urandom); bus8.rm = 2'($urandom);
        cyc = 1;
        while (bus8.done !== 1'b1 && cyc < 12) begin
            @(posedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1;
        $display("[TB] op8 wsrc=%0d rd=%0d rm=%0d shift=%0d cycles=%0d result=%h status=%b",
                 c.wsrc, c.rd, c.rm, c.sh, cyc, bus8.result, bus8.status);
    endtask

    function automatic cmd_t mk(input int wsrc, input int rd, input int rn, input int rm,
                                input int op, input int sh, input bit ui, input longint imm,
                                input bit wen, input bit ss);
        cmd_t c;
        c.wsrc = wsrc; c.rd = rd; c.rn = rn; c.rm = rm; c.op = op; c.sh = sh;
        c.az = 1'b0; c.ui = ui; c.imm = imm; c.wen = wen; c.ss = ss;
        return c;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        model_clear();
        n_tests++; if (bus16.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", bus16.ready); end
        n_tests++; if (bus16.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", bus16.done); end
        n_tests++; if (bus16.result !== 16'h0) begin n_fail++; $display("FAIL reset_result got %h exp 0000", bus16.result); end
        n_tests++; if (bus16.status !== 3'b000) begin n_fail++; $display("FAIL reset_status got %b exp 000", bus16.status); end
        for (int i = 0; i < 8; i++) begin
            bus16.dbg_addr = 3'(i); #1;
            n_tests++;
            if (bus16.dbg_data !== 16'h0) begin n_fail++; $display("FAIL reset_r%0d got %h exp 0000", i, bus16.dbg_data); end
        end
        n_tests++; if (bus8.ready !== 1'b1) begin n_fail++; $display("FAIL reset8_ready got %b exp 1", bus8.ready); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_load_imm();
        int cyc;
        logic [2:0] st_before;
        st_before = bus16.status;
        model16(mk(2, 0, 0, 0, 0, 0, 0, 16'h0007, 1, 1));
        issue16(mk(2, 0, 0, 0, 0, 0, 0, 16'h0007, 1, 1), cyc);
        n_tests++; if (cyc != 1) begin n_fail++; $display("FAIL ldi_latency got %0d exp 1", cyc); end
        bus16.dbg_addr = 3'd0; #1;
        n_tests++; if (bus16.dbg_data !== 16'h0007) begin n_fail++; $display("FAIL ldi_r0 got %h exp 0007", bus16.dbg_data); end
        n_tests++; if (bus16.status !== st_before) begin n_fail++; $display("FAIL ldi_status got %b exp %b", bus16.status, st_before); end

        bus16.mdata = 16'hBEEF;
        model16(mk(3, 3, 0, 0, 0, 0, 0, 0, 1, 0));
        issue16(mk(3, 3, 0, 0, 0, 0, 0, 0, 1, 0), cyc);
        bus16.dbg_addr = 3'd3; #1;
        n_tests++; if (bus16.dbg_data !== 16'hBEEF) begin n_fail++; $display("FAIL ldm_r3 got %h exp beef", bus16.dbg_data); end

        bus16.pc = 8'h2A;
        model16(mk(1, 4, 0, 0, 0, 0, 0, 0, 1, 0));
        issue16(mk(1, 4, 0, 0, 0, 0, 0, 0, 1, 0), cyc);
        bus16.dbg_addr = 3'd4; #1;
        n_tests++; if (bus16.dbg_data !== 16'h002A) begin n_fail++; $display("FAIL ldpc_r4 got %h exp 002a", bus16.dbg_data); end
    endtask

    task automatic test_add_shift();
        int cyc;
        model16(mk(2, 1, 0, 0, 0, 0, 0, 3, 1, 0)); issue16(mk(2, 1, 0, 0, 0, 0, 0, 3, 1, 0), cyc);
        model16(mk(2, 2, 0, 0, 0, 0, 0, 5, 1, 0)); issue16(mk(2, 2, 0, 0, 0, 0, 0, 5, 1, 0), cyc);
        model16(mk(0, 2, 1, 2, 0, 1, 0, 0, 1, 0)); issue16(mk(0, 2, 1, 2, 0, 1, 0, 0, 1, 0), cyc);
        n_tests++; if (cyc != 4) begin n_fail++; $display("FAIL add_latency got %0d exp 4", cyc); end
        n_tests++; if (bus16.result !== 16'd13) begin n_fail++; $display("FAIL add_result got %h exp 000d", bus16.result); end
        bus16.dbg_addr = 3'd2; #1;
        n_tests++; if (bus16.dbg_data !== 16'd13) begin n_fail++; $display("FAIL add_r2 got %h exp 000d", bus16.dbg_data); end
    endtask

    task automatic test_status();
        int cyc;
        model16(mk(2, 1, 0, 0, 0, 0, 0, 16'h7FFF, 1, 0)); issue16(mk(2, 1, 0, 0, 0, 0, 0, 16'h7FFF, 1, 0), cyc);
        model16(mk(2, 2, 0, 0, 0, 0, 0, 16'h0001, 1, 0)); issue16(mk(2, 2, 0, 0, 0, 0, 0, 16'h0001, 1, 0), cyc);
        model16(mk(0, 3, 1, 2, 0, 0, 0, 0, 1, 1)); issue16(mk(0, 3, 1, 2, 0, 0, 0, 0, 1, 1), cyc);
        n_tests++; if (bus16.result !== 16'h8000) begin n_fail++; $display("FAIL ovf_add_result got %h exp 8000", bus16.result); end
        n_tests++; if (bus16.status !== 3'b110) begin n_fail++; $display("FAIL ovf_add_status got %b exp 110", bus16.status); end
        model16(mk(0, 4, 3, 2, 1, 0, 0, 0, 1, 1)); issue16(mk(0, 4, 3, 2, 1, 0, 0, 0, 1, 1), cyc);
        n_tests++; if (bus16.result !== 16'h7FFF) begin n_fail++; $display("FAIL ovf_sub_result got %h exp 7fff", bus16.result); end
        n_tests++; if (bus16.status !== 3'b100) begin n_fail++; $display("FAIL ovf_sub_status got %b exp 100", bus16.status); end
        model16(mk(0, 5, 1, 1, 1, 0, 0, 0, 1, 1)); issue16(mk(0, 5, 1, 1, 1, 0, 0, 0, 1, 1), cyc);
        n_tests++; if (bus16.status !== 3'b001) begin n_fail++; $display("FAIL zero_sub_status got %b exp 001", bus16.status); end
    endtask

    task automatic test_random();
        cmd_t c;
        int cyc;
        for (int t = 0; t < 40; t++) begin
            c.rd = $urandom_range(0, 7); c.rn = $urandom_range(0, 7); c.rm = $urandom_range(0, 7);
            c.op = $urandom_range(0, 3); c.sh = $urandom_range(0, 3);
            c.az = 1'($urandom_range(0, 1)); c.ui = 1'($urandom_range(0, 1));
            c.imm = $urandom_range(0, 65535);
            c.wsrc = ($urandom_range(0, 2) != 0) ? 0 : $urandom_range(1, 3);
            c.wen = ($urandom_range(0, 3) != 0); c.ss = 1'($urandom_range(0, 1));
            bus16.mdata = 16'($urandom); bus16.pc = 8'($urandom);
            model16(c);
            issue16(c, cyc);
            n_tests++;
            if (cyc != ((c.wsrc == 0) ? 4 : 1)) begin n_fail++; $display("FAIL rnd%0d_latency got %0d exp %0d", t, cyc, (c.wsrc == 0) ? 4 : 1); end
            n_tests++; if (bus16.result !== m_c) begin n_fail++; $display("FAIL rnd%0d_result got %h exp %h", t, bus16.result, m_c); end
            n_tests++; if (bus16.status !== m_status) begin n_fail++; $display("FAIL rnd%0d_status got %b exp %b", t, bus16.status, m_status); end
            for (int i = 0; i < 8; i++) begin
                bus16.dbg_addr = 3'(i); #1;
                n_tests++;
                if (bus16.dbg_data !== m_regs[i]) begin n_fail++; $display("FAIL rnd%0d_r%0d got %h exp %h", t, i, bus16.dbg_data, m_regs[i]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc, accepts, dones, guard;
        cmd_t inc, ld7;
        model16(mk(2, 5, 0, 0, 0, 0, 0, 10, 1, 0)); issue16(mk(2, 5, 0, 0, 0, 0, 0, 10, 1, 0), cyc);
        inc = mk(0, 5, 5, 5, 0, 0, 1, 1, 1, 0);
        bus16.rd = 3'd5; bus16.rn = 3'd5; bus16.rm = 3'd5; bus16.alu_op = 2'd0; bus16.shift = 2'd0;
        bus16.a_zero = 1'b0; bus16.use_imm = 1'b1; bus16.imm = 16'd1; bus16.wsrc = 2'd0;
        bus16.wen = 1'b1; bus16.set_status = 1'b0; bus16.start = 1'b1;
        accepts = 0; dones = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus16.ready === 1'b1) begin accepts++; model16(inc); end
            @(posedge clk); #1;
            if (bus16.done === 1'b1) dones++;
        end
        bus16.start = 1'b0;
        guard = 0;
        while (bus16.ready !== 1'b1 && guard < 10) begin
            @(posedge clk); #1;
            guard++;
            if (bus16.done === 1'b1) dones++;
        end
        $display("[TB] held-start accepts=%0d dones=%0d", accepts, dones);
        n_tests++; if (accepts != 3) begin n_fail++; $display("FAIL held_accepts got %0d exp 3", accepts); end
        n_tests++; if (dones != 3) begin n_fail++; $display("FAIL held_dones got %0d exp 3", dones); end
        bus16.dbg_addr = 3'd5; #1;
        n_tests++; if (bus16.dbg_data !== 16'd13) begin n_fail++; $display("FAIL held_r5 got %h exp 000d", bus16.dbg_data); end

        // start pulsed while the previous op sits in LD_B must be dropped
        model16(mk(0, 6, 5, 5, 0, 0, 1, 2, 1, 0));
        ld7 = mk(2, 7, 0, 0, 0, 0, 0, 16'h0055, 1, 0);
        bus16.rd = 3'd6; bus16.rn = 3'd5; bus16.rm = 3'd5; bus16.imm = 16'd2; bus16.start = 1'b1;
        @(posedge clk); #1;
        bus16.start = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (bus16.ready !== 1'b0) begin n_fail++; $display("FAIL ldb_ready got %b exp 0", bus16.ready); end
        bus16.rd = 3'(ld7.rd); bus16.wsrc = 2'(ld7.wsrc); bus16.imm = 16'(ld7.imm); bus16.start = 1'b1;
        @(posedge clk); #1;
        bus16.start = 1'b0;
        dones = 0; guard = 0;
        if (bus16.done === 1'b1) dones++;
        while (guard < 8) begin
            @(posedge clk); #1;
            guard++;
            if (bus16.done === 1'b1) dones++;
        end
        n_tests++; if (dones != 1) begin n_fail++; $display("FAIL ldb_dones got %0d exp 1", dones); end
        bus16.dbg_addr = 3'd7; #1;
        n_tests++; if (bus16.dbg_data !== m_regs[7]) begin n_fail++; $display("FAIL ldb_r7 got %h exp %h", bus16.dbg_data, m_regs[7]); end
        bus16.dbg_addr = 3'd6; #1;
        n_tests++; if (bus16.dbg_data !== m_regs[6]) begin n_fail++; $display("FAIL ldb_r6 got %h exp %h", bus16.dbg_data, m_regs[6]); end
    endtask

    task automatic test_reset_mid();
        int cyc, bad;
        issue16(mk(2, 1, 0, 0, 0, 0, 0, 5, 1, 0), cyc);
        bus16.dbg_addr = 3'd1; #1;
        n_tests++; if (bus16.dbg_data !== 16'd5) begin n_fail++; $display("FAIL mid_pre_r1 got %h exp 0005", bus16.dbg_data); end
        bus16.rd = 3'd1; bus16.rn = 3'd1; bus16.rm = 3'd1; bus16.alu_op = 2'd0; bus16.shift = 2'd0;
        bus16.a_zero = 1'b0; bus16.use_imm = 1'b0; bus16.wsrc = 2'd0; bus16.wen = 1'b1;
        bus16.set_status = 1'b1; bus16.start = 1'b1;
        @(posedge clk); #1;
        bus16.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; #1;
        model_clear();
        n_tests++; if (bus16.ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready got %b exp 1", bus16.ready); end
        n_tests++; if (bus16.done !== 1'b0) begin n_fail++; $display("FAIL mid_done got %b exp 0", bus16.done); end
        n_tests++; if (bus16.result !== 16'h0) begin n_fail++; $display("FAIL mid_result got %h exp 0000", bus16.result); end
        n_tests++; if (bus16.status !== 3'b000) begin n_fail++; $display("FAIL mid_status got %b exp 000", bus16.status); end
        n_tests++; if (bus16.dbg_data !== 16'h0) begin n_fail++; $display("FAIL mid_r1 got %h exp 0000", bus16.dbg_data); end
        @(posedge clk); #1;
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (bus16.done !== 1'b0 || bus16.ready !== 1'b1) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL mid_after_idle got %0d bad cycles exp 0", bad); end
        n_tests++; if (bus16.dbg_data !== 16'h0) begin n_fail++; $display("FAIL mid_after_r1 got %h exp 0000", bus16.dbg_data); end
    endtask

    task automatic test_width8();
        int cyc;
        cmd_t c;
        issue8(mk(2, 1, 0, 0, 0, 0, 0, 8'h80, 1, 0), cyc);
        c = mk(0, 2, 0, 1, 0, 3, 0, 0, 1, 1); c.az = 1'b1;
        issue8(c, cyc);
        n_tests++; if (cyc != 4) begin n_fail++; $display("FAIL w8_latency got %0d exp 4", cyc); end
        n_tests++; if (bus8.result !== 8'hC0) begin n_fail++; $display("FAIL w8_asr_result got %h exp c0", bus8.result); end
        n_tests++; if (bus8.status !== 3'b010) begin n_fail++; $display("FAIL w8_asr_status got %b exp 010", bus8.status); end
        bus8.dbg_addr = 2'd2; #1;
        n_tests++; if (bus8.dbg_data !== 8'hC0) begin n_fail++; $display("FAIL w8_asr_r2 got %h exp c0", bus8.dbg_data); end
        c = mk(0, 3, 0, 1, 0, 2, 0, 0, 1, 1); c.az = 1'b1;
        issue8(c, cyc);
        n_tests++; if (bus8.result !== 8'h40) begin n_fail++; $display("FAIL w8_lsr_result got %h exp 40", bus8.result); end
        n_tests++; if (bus8.status !== 3'b000) begin n_fail++; $display("FAIL w8_lsr_status got %b exp 000", bus8.status); end
        bus8.dbg_addr = 2'd3; #1;
        n_tests++; if (bus8.dbg_data !== 8'h40) begin n_fail++; $display("FAIL w8_lsr_r3 got %h exp 40", bus8.dbg_data); end
    endtask

    initial begin
        bus16.start = 1'b0; bus16.rd = '0; bus16.rn = '0; bus16.rm = '0; bus16.alu_op = '0;
        bus16.shift = '0; bus16.a_zero = 1'b0; bus16.use_imm = 1'b0; bus16.imm = '0;
        bus16.wsrc = '0; bus16.wen = 1'b0; bus16.set_status = 1'b0; bus16.mdata = '0;
        bus16.pc = '0; bus16.dbg_addr = '0;
        bus8.start = 1'b0; bus8.rd = '0; bus8.rn = '0; bus8.rm = '0; bus8.alu_op = '0;
        bus8.shift = '0; bus8.a_zero = 1'b0; bus8.use_imm = 1'b0; bus8.imm = '0;
        bus8.wsrc = '0; bus8.wen = 1'b0; bus8.set_status = 1'b0; bus8.mdata = '0;
        bus8.pc = '0; bus8.dbg_addr = '0;
        model_clear();
        test_reset();
        test_load_imm();
        test_add_shift();
        test_status();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_width8();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/datapath_seq.md
Name: datapath_seq

Overview:
- Parametrised, self-sequencing successor of the single-cycle-controlled datapath.
- Holds a register file of NREGS x WIDTH plus A/B/C operand/result registers and a {V,N,Z} status register.
- Executes one register-to-register or load-immediate operation per start/done handshake with an internal FSM, so the controller no longer drives loada/loadb/loadc/write per cycle.
- Sits between the instruction decoder/controller and memory (mdata) in the CPU.

Parameters:
WIDTH, 16, datapath width in bits (>=4)
NREGS, 8, register count (power of 2, >=2); AW = clog2(NREGS)
PCW, 8, program-counter width, zero-extended to WIDTH on writeback (PCW<=WIDTH)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  operation request; accepted only when ready=1
rd  input  AW  destination register
rn  input  AW  A-operand register
rm  input  AW  B-operand register
alu_op  input  2  00 add, 01 sub (A-B), 10 and, 11 not B
shift  input  2  B-path shift: 00 none, 01 lsl 1, 10 lsr 1 (zero fill), 11 asr 1
a_zero  input  1  1: ALU A input forced to 0
use_imm  input  1  1: ALU B input = imm instead of shifted B
imm  input  WIDTH  sign-extended immediate
wsrc  input  2  writeback source: 00 C, 01 zero-extended pc, 10 imm, 11 mdata
wen  input  1  write rd at writeback
set_status  input  1  update status at EXEC
mdata  input  WIDTH  memory read data
pc  input  PCW  program counter
ready  output  1  FSM idle, start will be accepted
done  output  1  one-cycle pulse in WB state
result  output  WIDTH  C register
status  output  3  {V,N,Z}
dbg_addr  input  AW  debug read address
dbg_data  output  WIDTH  combinational regfile[dbg_addr]

Behaviour:
- All request fields are captured into an internal command register on the accept edge (start & ready); inputs may change afterwards. Exception: mdata and pc are sampled live at the WB edge.
- FSM states: IDLE, LD_A, LD_B, EXEC, WB.
- IDLE: ready=1. On accept: wsrc=00 -> LD_A; otherwise -> WB (EXEC path skipped; A/B/C/status untouched).
- LD_A: A <= reg[rn]. Next: LD_B.
- LD_B: B <= reg[rm]. Next: EXEC.
- EXEC: C <= ALU(Ain, Bin). Ain = a_zero ? 0 : A. Bin = use_imm ? imm : shift(B). If set_status, status <= {V,N,Z}. Next: WB.
- WB: done=1. If wen, reg[rd] <= selected wsrc value at this edge (C is already updated). Next: IDLE.
- ready is high only in IDLE; start in any other state is ignored (no queueing).
- Latency: accept edge at cycle 0 -> done high during cycle 4 (ALU path) or cycle 1 (wsrc!=00); next accept possible the cycle after done.
- Arithmetic: modulo 2^WIDTH.
  - Z = (out==0).
  - N = out[WIDTH-1].
  - V (add) = (Ain[msb]==Bin[msb]) & (out[msb]!=Ain[msb]).
  - V (sub) = (Ain[msb]!=Bin[msb]) & (out[msb]!=Ain[msb]).
  - V = 0 for and/not.
- asr replicates bit WIDTH-1; lsl drops bit WIDTH-1.
- rd may equal rn/rm; the read occurs before the write, so there is no hazard.
- Reset (any time, including mid-operation): FSM -> IDLE, ready=1, done=0, A=B=C=0, status=0, all registers 0. An aborted operation performs no register write.
- dbg_data reflects a write starting the cycle after the WB edge.

Test Plan:
- Reset mid-EXEC after a prior write of 5 into r1 -> ready=1, done=0, result=0, status=000, dbg_data(r1)=0; no write to rd.
- Load-immediate: start with wsrc=10, imm=0x0007, rd=r0, wen=1 -> done one cycle after accept, r0=7, status unchanged; then wsrc=11, mdata=0xBEEF, rd=r3 -> r3=0xBEEF; then wsrc=01, pc=0x2A, rd=r4 -> r4=0x002A.
- Add with shift: r1=3, r2=5, rd=r2, rn=r1, rm=r2, alu_op=00, shift=01 -> done at cycle 4, r2=13, result=13.
- Overflow/status: r1=0x7FFF, r2=0x0001, add with set_status -> result=0x8000, status=110. Sub 0x8000-0x0001 -> 0x7FFF, status=100. Sub r1-r1 -> status=001.
- Handshake: start held high continuously -> operations accepted only in IDLE, one done per operation, no duplicate writes; start pulsed during LD_B -> ignored.
- Parameter sweep: WIDTH=8, NREGS=4. asr of 0x80 via rm, a_zero=1, add -> 0xC0, N=1. lsr of 0x80 -> 0x40.
